// File: rtl/axi_rw_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : axi_rw_arbiter_if
// Brief    : Requester-side and axi_rw-side signal bundle for axi_rw_arbiter.
//            slave = arbiter view, master = surrounding requesters/axi_rw view.
// Revision : 1.0
// ============================================================================
interface axi_rw_arbiter_if #(
  parameter int RW_DATA_WIDTH = 64,
  parameter int RW_ADDR_WIDTH = 64
);
  logic                     if_valid_i;
  logic                     if_ready_o;
  logic [RW_ADDR_WIDTH-1:0] if_addr_i;
  logic [1:0]               if_size_i;
  logic [RW_DATA_WIDTH-1:0] if_rdata_o;
  logic [1:0]               if_resp_o;

  logic                     mem_valid_i;
  logic                     mem_ready_o;
  logic                     mem_req_i;
  logic [RW_ADDR_WIDTH-1:0] mem_addr_i;
  logic [1:0]               mem_size_i;
  logic [RW_DATA_WIDTH-1:0] mem_wdata_i;
  logic [7:0]               mem_strb_i;
  logic [RW_DATA_WIDTH-1:0] mem_rdata_o;
  logic [1:0]               mem_resp_o;

  logic                     rw_valid_o;
  logic                     rw_ready_i;
  logic                     rw_req_o;
  logic [RW_ADDR_WIDTH-1:0] rw_addr_o;
  logic [1:0]               rw_size_o;
  logic [RW_DATA_WIDTH-1:0] data_write_o;
  logic [7:0]               strb_mask_o;
  logic [RW_DATA_WIDTH-1:0] data_read_i;
  logic [1:0]               rw_resp_i;
  logic                     axi_sig_mem_o;

  modport slave (
    input  if_valid_i, if_addr_i, if_size_i,
    output if_ready_o, if_rdata_o, if_resp_o,
    input  mem_valid_i, mem_req_i, mem_addr_i, mem_size_i, mem_wdata_i, mem_strb_i,
    output mem_ready_o, mem_rdata_o, mem_resp_o,
    output rw_valid_o, rw_req_o, rw_addr_o, rw_size_o, data_write_o, strb_mask_o,
    output axi_sig_mem_o,
    input  rw_ready_i, data_read_i, rw_resp_i
  );

  modport master (
    output if_valid_i, if_addr_i, if_size_i,
    input  if_ready_o, if_rdata_o, if_resp_o,
    output mem_valid_i, mem_req_i, mem_addr_i, mem_size_i, mem_wdata_i, mem_strb_i,
    input  mem_ready_o, mem_rdata_o, mem_resp_o,
    input  rw_valid_o, rw_req_o, rw_addr_o, rw_size_o, data_write_o, strb_mask_o,
    input  axi_sig_mem_o,
    output rw_ready_i, data_read_i, rw_resp_i
  );
endinterface
`default_nettype wire

// File: rtl/axi_rw_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : axi_rw_arbiter
// Brief    : Shares the axi_rw master port between IF (read-only) and MEM.
//            Define ARB_RR_EN for round-robin; otherwise MEM has fixed priority.
// Revision : 1.0
// ============================================================================
module axi_rw_arbiter #(
  parameter int RW_DATA_WIDTH = 64,
  parameter int RW_ADDR_WIDTH = 64
) (
  input wire               clock,
  input wire               reset,
  axi_rw_arbiter_if.slave  bus
);

  localparam logic c_REQ_READ = 1'b0;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BUSY_IF  = 2'd1,
    BUSY_MEM = 2'd2
  } state_t;

  state_t                   r_state;
  logic                     r_req;
  logic [RW_ADDR_WIDTH-1:0] r_addr;
  logic [1:0]               r_size;
  logic [RW_DATA_WIDTH-1:0] r_wdata;
  logic [7:0]               r_strb;
  logic                     r_sig_mem;
  logic                     w_grant_mem;
  logic                     w_busy;

`ifdef ARB_RR_EN
  logic r_last_mem;

  // On conflict the side not granted last wins; a lone requester always wins.
  always_comb w_grant_mem = bus.mem_valid_i & (~bus.if_valid_i | ~r_last_mem);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_last_mem <= 1'b0;
    end else if (r_state == IDLE && (bus.mem_valid_i || bus.if_valid_i)) begin
      r_last_mem <= w_grant_mem;
    end
  end
`else
  always_comb w_grant_mem = bus.mem_valid_i;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_req     <= 1'b0;
      r_addr    <= '0;
      r_size    <= 2'd0;
      r_wdata   <= '0;
      r_strb    <= 8'd0;
      r_sig_mem <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant_mem) begin
            r_state   <= BUSY_MEM;
            r_req     <= bus.mem_req_i;
            r_addr    <= bus.mem_addr_i;
            r_size    <= bus.mem_size_i;
            r_wdata   <= bus.mem_wdata_i;
            r_strb    <= bus.mem_strb_i;
            r_sig_mem <= 1'b1;
          end else if (bus.if_valid_i) begin
            r_state   <= BUSY_IF;
            r_req     <= c_REQ_READ;
            r_addr    <= bus.if_addr_i;
            r_size    <= bus.if_size_i;
            r_wdata   <= '0;
            r_strb    <= 8'd0;
            r_sig_mem <= 1'b0;
          end
        end
        BUSY_IF, BUSY_MEM: begin
          if (bus.rw_ready_i) begin
            r_state   <= IDLE;
            r_sig_mem <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign w_busy = (r_state != IDLE);

  // Valid drops in the ready cycle so axi_rw never sees a relaunch.
  assign bus.rw_valid_o    = w_busy & ~bus.rw_ready_i;
  assign bus.rw_req_o      = r_req;
  assign bus.rw_addr_o     = r_addr;
  assign bus.rw_size_o     = r_size;
  assign bus.data_write_o  = r_wdata;
  assign bus.strb_mask_o   = r_strb;
  assign bus.axi_sig_mem_o = r_sig_mem;

  assign bus.if_ready_o  = (r_state == BUSY_IF)  & bus.rw_ready_i;
  assign bus.mem_ready_o = (r_state == BUSY_MEM) & bus.rw_ready_i;
  assign bus.if_rdata_o  = bus.data_read_i;
  assign bus.if_resp_o   = bus.rw_resp_i;
  assign bus.mem_rdata_o = bus.data_read_i;
  assign bus.mem_resp_o  = bus.rw_resp_i;

endmodule
`default_nettype wire

// File: tb/tb_axi_rw_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_rw_arbiter
// Brief    : Scoreboard bench for axi_rw_arbiter (honours ARB_RR_EN).
// Revision : 1.0
// ============================================================================
module tb_axi_rw_arbiter;

  typedef struct packed {
    logic        req;
    logic [63:0] addr;
    logic [1:0]  size;
    logic [63:0] wdata;
    logic [7:0]  strb;
    logic        mem;
  } txn_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  axi_rw_arbiter_if bus ();
  axi_rw_arbiter dut (.clock(clock), .reset(reset), .bus(bus));

  int tests = 0;
  int fails = 0;

  txn_t        exp_q[$];
  logic [65:0] cmp_q[$];
  logic        dut_log[$];
  int          gap_q[$];

  int  m_owner = 0;     // 0 none, 1 IF, 2 MEM
  bit  m_last_mem = 0;
  bit  if_done = 0, mem_done = 0;

  bit          random_mode = 0, hold_resp = 0, use_fixed = 0;
  logic [63:0] fixed_data = '0;
  int          wcnt = 0, wmin = 0, wmax = 3;
  int          mem_rdy_cnt = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: one transaction in flight, grant chosen from pending requests.
  initial begin
    int   pick;
    txn_t t;
    forever begin
      @(posedge clock or posedge reset);
      if_done = 0;
      mem_done = 0;
      if (reset) begin
        m_owner = 0;
        m_last_mem = 0;
        exp_q.delete();
      end else if (m_owner != 0) begin
        if (bus.rw_ready_i) begin
          if (m_owner == 1) if_done = 1; else mem_done = 1;
          m_owner = 0;
        end
      end else begin
        if (bus.if_valid_i && bus.mem_valid_i) begin
`ifdef ARB_RR_EN
          pick = m_last_mem ? 1 : 2;
`else
          pick = 2;
`endif
        end else if (bus.mem_valid_i) pick = 2;
        else if (bus.if_valid_i) pick = 1;
        else pick = 0;
        if (pick == 2) begin
          t = '{bus.mem_req_i, bus.mem_addr_i, bus.mem_size_i, bus.mem_wdata_i, bus.mem_strb_i, 1'b1};
          exp_q.push_back(t);
        end else if (pick == 1) begin
          t = '{1'b0, bus.if_addr_i, bus.if_size_i, 64'd0, 8'd0, 1'b0};
          exp_q.push_back(t);
        end
        if (pick != 0) begin
          m_owner = pick;
          m_last_mem = (pick == 2);
        end
      end
    end
  end

  // Monitor: compares DUT outputs each cycle, pops the scoreboard when a transaction shows up.
  initial begin
    txn_t        cur;
    logic [65:0] c;
    bit          have_cur = 0, prev_valid = 0;
    int          mcyc = 0, last_rdy = -1;
    forever begin
      @(negedge clock);
      #2;
      mcyc++;
      if (reset) begin
        chk("rst_rw_valid", bus.rw_valid_o, 0);
        chk("rst_if_ready", bus.if_ready_o, 0);
        chk("rst_mem_ready", bus.mem_ready_o, 0);
        chk("rst_sig_mem", bus.axi_sig_mem_o, 0);
        chk("rst_rw_addr", bus.rw_addr_o, 0);
        have_cur = 0;
        prev_valid = 0;
        continue;
      end
      chk("rw_valid", bus.rw_valid_o, (m_owner != 0) && !bus.rw_ready_i);
      chk("if_ready", bus.if_ready_o, (m_owner == 1) && bus.rw_ready_i);
      chk("mem_ready", bus.mem_ready_o, (m_owner == 2) && bus.rw_ready_i);
      if (!have_cur && (bus.rw_valid_o || bus.if_ready_o || bus.mem_ready_o)) begin
        if (exp_q.size() == 0) chk("unexpected_txn", 1, 0);
        else begin
          cur = exp_q.pop_front();
          have_cur = 1;
          dut_log.push_back(bus.axi_sig_mem_o);
        end
      end
      if (have_cur) begin
        chk("rw_req", bus.rw_req_o, cur.req);
        chk("rw_addr", bus.rw_addr_o, cur.addr);
        chk("rw_size", bus.rw_size_o, cur.size);
        chk("data_write", bus.data_write_o, cur.wdata);
        chk("strb_mask", bus.strb_mask_o, cur.strb);
        chk("axi_sig_mem", bus.axi_sig_mem_o, cur.mem);
      end
      if (bus.rw_valid_o && !prev_valid && last_rdy >= 0) gap_q.push_back(mcyc - last_rdy);
      prev_valid = bus.rw_valid_o;
      if (bus.if_ready_o || bus.mem_ready_o) begin
        if (cmp_q.size() == 0) chk("unexpected_ready", 1, 0);
        else begin
          c = cmp_q.pop_front();
          if (bus.if_ready_o) begin
            chk("if_rdata", bus.if_rdata_o, c[63:0]);
            chk("if_resp", bus.if_resp_o, c[65:64]);
          end else begin
            chk("mem_rdata", bus.mem_rdata_o, c[63:0]);
            chk("mem_resp", bus.mem_resp_o, c[65:64]);
            mem_rdy_cnt++;
          end
        end
        last_rdy = mcyc;
        have_cur = 0;
      end
    end
  end

  task automatic new_if();
    bus.if_valid_i = 1;
    bus.if_addr_i  = {$urandom, $urandom};
    bus.if_size_i  = 2'($urandom_range(0, 3));
  endtask

  task automatic new_mem();
    bus.mem_valid_i = 1;
    bus.mem_req_i   = 1'($urandom_range(0, 1));
    bus.mem_addr_i  = {$urandom, $urandom};
    bus.mem_size_i  = 2'($urandom_range(0, 3));
    bus.mem_wdata_i = {$urandom, $urandom};
    bus.mem_strb_i  = 8'($urandom_range(0, 255));
  endtask

  // One clock of stimulus: axi_rw responder plus (in random mode) both requesters.
  task automatic cyc();
    @(negedge clock);
    if (m_owner != 0 && !hold_resp) begin
      if (wcnt == 0) begin
        bus.rw_ready_i  = 1;
        bus.data_read_i = use_fixed ? fixed_data : {$urandom, $urandom};
        bus.rw_resp_i   = 2'($urandom_range(0, 3));
        cmp_q.push_back({bus.rw_resp_i, bus.data_read_i});
        wcnt = $urandom_range(wmin, wmax);
      end else begin
        bus.rw_ready_i = 0;
        wcnt--;
      end
    end else begin
      bus.rw_ready_i  = random_mode && ($urandom_range(0, 7) == 0);
      bus.data_read_i = {$urandom, $urandom};
      bus.rw_resp_i   = 2'($urandom_range(0, 3));
    end
    if (random_mode) begin
      if (if_done) begin
        if ($urandom_range(0, 1) == 1) new_if(); else bus.if_valid_i = 0;
      end else if (!bus.if_valid_i && $urandom_range(0, 2) == 0) new_if();
      if (mem_done) begin
        if ($urandom_range(0, 1) == 1) new_mem(); else bus.mem_valid_i = 0;
      end else if (!bus.mem_valid_i && $urandom_range(0, 2) == 0) new_mem();
      if (m_owner == 2 && $urandom_range(0, 3) == 0) bus.mem_addr_i = {$urandom, $urandom};
    end
  endtask

  // Runs until the chosen requester completes n times, dropping its valid on the last.
  task automatic wait_done(input bit is_mem, input int n);
    int got = 0;
    for (int i = 0; i < 200 && got < n; i++) begin
      cyc();
      if (is_mem ? mem_done : if_done) begin
        got++;
        if (got == n) begin
          if (is_mem) bus.mem_valid_i = 0; else bus.if_valid_i = 0;
        end
      end
    end
    if (got < n) chk("timeout_wait_done", 0, 1);
  endtask

  initial begin
    logic exp_rr [4];
    bus.if_valid_i = 0; bus.if_addr_i = '0; bus.if_size_i = 0;
    bus.mem_valid_i = 0; bus.mem_req_i = 0; bus.mem_addr_i = '0; bus.mem_size_i = 0;
    bus.mem_wdata_i = '0; bus.mem_strb_i = 0;
    bus.rw_ready_i = 0; bus.data_read_i = '0; bus.rw_resp_i = 0;
    repeat (3) @(negedge clock);
    reset = 0;
    repeat (2) cyc();

    // Conflict: MEM first, then IF
    dut_log.delete();
    bus.mem_valid_i = 1; bus.mem_req_i = 0; bus.mem_addr_i = 64'h100; bus.mem_size_i = 3;
    bus.if_valid_i = 1; bus.if_addr_i = 64'h200; bus.if_size_i = 2;
    wait_done(1, 1);
    wait_done(0, 1);
    chk("conflict_log_size", dut_log.size(), 2);
    if (dut_log.size() >= 2) begin
      chk("conflict_first_mem", dut_log[0], 1);
      chk("conflict_second_if", dut_log[1], 0);
    end

    // Repeated conflicts with both held for four grants
`ifdef ARB_RR_EN
    exp_rr = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
    exp_rr = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
    dut_log.delete();
    bus.mem_valid_i = 1; bus.if_valid_i = 1;
    begin
      int done_n = 0;
      for (int i = 0; i < 200 && done_n < 4; i++) begin
        cyc();
        if (if_done || mem_done) done_n++;
      end
      bus.mem_valid_i = 0; bus.if_valid_i = 0;
      if (done_n < 4) chk("timeout_repeat", 0, 1);
    end
    chk("repeat_log_size", dut_log.size(), 4);
    for (int i = 0; i < 4 && i < dut_log.size(); i++) chk("repeat_grant", dut_log[i], exp_rr[i]);
    repeat (6) cyc();

    // IF read alone, data 0x13
    use_fixed = 1; fixed_data = 64'h13; wcnt = 1;
    bus.if_valid_i = 1; bus.if_addr_i = 64'h8000_0000; bus.if_size_i = 2'd2;
    wait_done(0, 1);
    use_fixed = 0;

    // MEM write, address scrambled mid-transaction
    wcnt = 3;
    bus.mem_valid_i = 1; bus.mem_req_i = 1; bus.mem_addr_i = 64'h8000_0010; bus.mem_size_i = 2'd2;
    bus.mem_wdata_i = 64'hDEAD_BEEF; bus.mem_strb_i = 8'h0F;
    repeat (2) cyc();
    bus.mem_addr_i = 64'h1234_5678;
    wait_done(1, 1);
    repeat (2) cyc();

    // Back-to-back MEM: one idle bubble between valid pulses
    wmin = 1; wmax = 1; wcnt = 1; mem_rdy_cnt = 0;
    bus.mem_valid_i = 1; bus.mem_req_i = 0; bus.mem_addr_i = 64'h40;
    wait_done(1, 1);
    bus.mem_valid_i = 1;
    gap_q.delete();
    wait_done(1, 1);
    repeat (2) cyc();
    chk("b2b_mem_ready_pulses", mem_rdy_cnt, 2);
    chk("b2b_gap_seen", gap_q.size() >= 1, 1);
    if (gap_q.size() >= 1) chk("b2b_gap_cycles", gap_q[0], 2);
    wmin = 0; wmax = 3;

    // Reset while BUSY_IF
    hold_resp = 1;
    bus.if_valid_i = 1; bus.if_addr_i = 64'h77; bus.if_size_i = 1;
    for (int i = 0; i < 10 && m_owner != 1; i++) cyc();
    chk("busy_if_reached", m_owner, 1);
    cyc();
    @(negedge clock);
    reset = 1;
    bus.rw_ready_i = 1;
    #1;
    chk("midrst_rw_valid", bus.rw_valid_o, 0);
    chk("midrst_if_ready", bus.if_ready_o, 0);
    chk("midrst_sig_mem", bus.axi_sig_mem_o, 0);
    chk("midrst_rw_addr", bus.rw_addr_o, 0);
    bus.if_valid_i = 0;
    bus.rw_ready_i = 0;
    cmp_q.delete();
    repeat (2) @(negedge clock);
    reset = 0;
    hold_resp = 0;
    repeat (4) cyc();

    // Randomized traffic
    random_mode = 1;
    repeat (3000) cyc();
    random_mode = 0;
    bus.if_valid_i = 0;
    bus.mem_valid_i = 0;
    repeat (12) cyc();
    chk("exp_q_drained", exp_q.size(), 0);
    chk("cmp_q_drained", cmp_q.size(), 0);

    @(negedge clock);
    #4;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
